// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Small FIFO of committed stores between the MEM stage and the data cache.
//   Stores are aligned and lane-replicated on entry, drained one at a time to
//   the cache, and checked against the address of the load in MEM so the load
//   can stall (or, with forwarding enabled, take a full-word hit).
//
//   Configuration macro: STORE_BUFFER_FWD_EN enables full-word load forwarding.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_st_valid / o_st_ready      store handshake from MEM
//   i_st_funct3, i_st_addr,
//   i_st_data                    store width, byte address, unaligned rs2 data
//   o_st_misalign                one-cycle pulse for a rejected store
//   o_dmem_write, o_dmem_address,
//   o_dmem_wdata, o_dmem_wmask   write request to the data cache
//   i_dmem_resp                  cache completes the current write
//   i_ld_addr                    address of the load in MEM
//   o_ld_stall, o_ld_fwd_hit,
//   o_ld_fwd_data                load hazard / forwarding result
//   o_sb_empty                   nothing buffered and no write outstanding
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    input  logic [2:0]  i_st_funct3,
    input  logic [31:0] i_st_addr,
    input  logic [31:0] i_st_data,
    output logic        o_st_misalign,
    output logic        o_dmem_write,
    output logic [31:0] o_dmem_address,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wmask,
    input  logic        i_dmem_resp,
    input  logic [31:0] i_ld_addr,
    output logic        o_ld_stall,
    output logic        o_ld_fwd_hit,
    output logic [31:0] o_ld_fwd_data,
    output logic        o_sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_st_misalign;
    logic [29:0]     r_addr [DEPTH];
    logic [3:0]      r_mask [DEPTH];
    logic [31:0]     r_data [DEPTH];

    logic            w_legal;
    logic [3:0]      w_mask;
    logic [31:0]     w_wdata;
    logic            w_hs;
    logic            w_push;
    logic            w_pop;
    logic            w_match_any;
    logic [1:0]      w_unused_ld_lo;

    assign w_unused_ld_lo = i_ld_addr[1:0];

    // Store alignment: byte-enable mask, lane replication and legality check.
    always_comb begin
        w_legal = 1'b0;
        w_mask  = 4'b0000;
        w_wdata = 32'h0000_0000;
        case (i_st_funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_mask  = 4'b0001 << i_st_addr[1:0];
                w_wdata = {4{i_st_data[7:0]}};
            end
            3'b001: begin
                w_legal = ~i_st_addr[0];
                w_mask  = i_st_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_st_data[15:0]}};
            end
            3'b010: begin
                w_legal = (i_st_addr[1:0] == 2'b00);
                w_mask  = 4'b1111;
                w_wdata = i_st_data;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // A full buffer refuses stores even when the head retires this cycle.
    assign o_st_ready = (r_count < CW'(DEPTH));
    assign w_hs       = i_st_valid & o_st_ready;
    assign w_push     = w_hs & w_legal;
    assign w_pop      = (r_state == S_WRITE) & i_dmem_resp;

    // Drain FSM next state: a response always returns to IDLE, which forces
    // one idle cycle between consecutive cache writes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != CW'(0)) || w_push) begin
                    w_state_next = S_WRITE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                if (i_dmem_resp) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_WRITE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, pointers, occupancy and the rejected-store pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= PW'(0);
            r_rd_ptr      <= PW'(0);
            r_count       <= CW'(0);
            r_st_misalign <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_st_misalign <= w_hs & ~w_legal;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail on a legal push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= 30'd0;
                r_mask[i] <= 4'b0000;
                r_data[i] <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_addr[r_wr_ptr] <= i_st_addr[31:2];
            r_mask[r_wr_ptr] <= w_mask;
            r_data[r_wr_ptr] <= w_wdata;
        end
    end

    assign o_dmem_write   = (r_state == S_WRITE);
    assign o_dmem_address = {r_addr[r_rd_ptr], 2'b00};
    assign o_dmem_wdata   = r_data[r_rd_ptr];
    assign o_dmem_wmask   = r_mask[r_rd_ptr];
    assign o_st_misalign  = r_st_misalign;
    assign o_sb_empty     = (r_count == CW'(0)) & (r_state == S_IDLE);

`ifdef STORE_BUFFER_FWD_EN
    logic        w_match_full;
    logic [31:0] w_match_data;

    // Walk oldest to youngest so the last match seen is the youngest one;
    // the head stays live here until it is popped.
    always_comb begin
        w_match_any  = 1'b0;
        w_match_full = 1'b0;
        w_match_data = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (r_addr[r_rd_ptr + PW'(i)] == i_ld_addr[31:2])) begin
                w_match_any  = 1'b1;
                w_match_full = (r_mask[r_rd_ptr + PW'(i)] == 4'b1111);
                w_match_data = r_data[r_rd_ptr + PW'(i)];
            end else begin
            end
        end
    end

    assign o_ld_fwd_hit  = w_match_full;
    assign o_ld_fwd_data = w_match_full ? w_match_data : 32'h0000_0000;
    assign o_ld_stall    = w_match_any & ~w_match_full;
`else
    // Any live entry in the load's word blocks the load.
    always_comb begin
        w_match_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (r_addr[r_rd_ptr + PW'(i)] == i_ld_addr[31:2])) begin
                w_match_any = 1'b1;
            end else begin
            end
        end
    end

    assign o_ld_fwd_hit  = 1'b0;
    assign o_ld_fwd_data = 32'h0000_0000;
    assign o_ld_stall    = w_match_any;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared
// every negedge, plus hand-computed literal expectations at key points.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr, st_data;
    logic        st_misalign;
    logic        dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp;
    logic [31:0] ld_addr;
    logic        ld_stall, ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        sb_empty;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_st_valid(st_valid), .o_st_ready(st_ready),
        .i_st_funct3(st_funct3), .i_st_addr(st_addr), .i_st_data(st_data),
        .o_st_misalign(st_misalign),
        .o_dmem_write(dmem_write), .o_dmem_address(dmem_address),
        .o_dmem_wdata(dmem_wdata), .o_dmem_wmask(dmem_wmask),
        .i_dmem_resp(dmem_resp), .i_ld_addr(ld_addr),
        .o_ld_stall(ld_stall), .o_ld_fwd_hit(ld_fwd_hit),
        .o_ld_fwd_data(ld_fwd_data), .o_sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [29:0] wa;
        logic [3:0]  m;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_wr  = 1'b0;
    bit   m_mis = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void decode(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d, output bit legal,
                                   output logic [3:0] m, output logic [31:0] wd);
        int off;
        off = int'(a % 32'd4);
        legal = 1'b0; m = 4'h0; wd = 32'h0;
        if (f == 3'd0) begin
            legal = 1'b1; m = 4'(1 << off); wd = {24'h0, d[7:0]} * 32'h0101_0101;
        end else if (f == 3'd1) begin
            legal = (off % 2) == 0; m = (off >= 2) ? 4'hC : 4'h3;
            wd = {16'h0, d[15:0]} * 32'h0001_0001;
        end else if (f == 3'd2) begin
            legal = (off == 0); m = 4'hF; wd = d;
        end
    endfunction

    function automatic void model_clear();
        q.delete();
        m_wr  = 1'b0;
        m_mis = 1'b0;
    endfunction

    // Advance the model by one rising edge using the inputs the DUT sees.
    function automatic void model_step();
        bit          acc, legal, push, pop, nwr;
        logic [3:0]  m;
        logic [31:0] wd;
        ent_t        e;
        if (rst) begin
            model_clear();
            return;
        end
        decode(st_funct3, st_addr, st_data, legal, m, wd);
        acc  = st_valid && (q.size() < DEPTH);
        push = acc && legal;
        pop  = m_wr && dmem_resp;
        nwr  = m_wr ? !dmem_resp : ((q.size() > 0) || push);
        if (pop) void'(q.pop_front());
        if (push) begin
            e.wa = st_addr[31:2]; e.m = m; e.d = wd;
            q.push_back(e);
        end
        m_mis = acc && !legal;
        m_wr  = nwr;
    endfunction

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        bit          any, full;
        logic [31:0] fd;
        any = 1'b0; full = 1'b0; fd = 32'h0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wa == ld_addr[31:2]) begin
                any = 1'b1; full = (q[i].m == 4'hF); fd = q[i].d;
                break;
            end
        end
        check("st_ready",    {31'd0, st_ready},    {31'd0, q.size() < DEPTH});
        check("sb_empty",    {31'd0, sb_empty},    {31'd0, (q.size() == 0) && !m_wr});
        check("dmem_write",  {31'd0, dmem_write},  {31'd0, m_wr});
        check("st_misalign", {31'd0, st_misalign}, {31'd0, m_mis});
        if (m_wr && q.size() > 0) begin
            check("dmem_address", dmem_address, {q[0].wa, 2'b00});
            check("dmem_wmask",   {28'd0, dmem_wmask}, {28'd0, q[0].m});
            check("dmem_wdata",   dmem_wdata, q[0].d);
        end
`ifdef STORE_BUFFER_FWD_EN
        check("ld_stall",    {31'd0, ld_stall},   {31'd0, any && !full});
        check("ld_fwd_hit",  {31'd0, ld_fwd_hit}, {31'd0, full});
        check("ld_fwd_data", ld_fwd_data, full ? fd : 32'h0);
`else
        check("ld_stall",    {31'd0, ld_stall},   {31'd0, any});
        check("ld_fwd_hit",  {31'd0, ld_fwd_hit}, 32'd0);
        check("ld_fwd_data", ld_fwd_data, 32'h0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        st_valid = 1'b1; st_funct3 = f; st_addr = a; st_data = d;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_funct3 = 3'd0; st_addr = 32'h0;
        st_data = 32'h0; dmem_resp = 1'b0; ld_addr = 32'hFFFF_FFF0;
        step(); step();
        check("rst_st_ready", {31'd0, st_ready}, 32'd1);
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_dmem_write", {31'd0, dmem_write}, 32'd0);
        rst = 1'b0;
        step();

        // sb 0xAB at 0x1003: write visible the next cycle
        store(3'b000, 32'h0000_1003, 32'h0000_00AB);
        step();
        st_valid = 1'b0; ld_addr = 32'h0000_1000;
        check("sb_write",   {31'd0, dmem_write}, 32'd1);
        check("sb_address", dmem_address, 32'h0000_1000);
        check("sb_wmask",   {28'd0, dmem_wmask}, 32'h0000_0008);
        check("sb_wdata",   dmem_wdata, 32'hABAB_ABAB);
        step();
        dmem_resp = 1'b1; step();
        dmem_resp = 1'b0;
        check("sb_done_write", {31'd0, dmem_write}, 32'd0);
        check("sb_done_empty", {31'd0, sb_empty}, 32'd1);

        // rejected stores: sw at 0x2002, sh at 0x2001, funct3 011
        store(3'b010, 32'h0000_2002, 32'h1234_5678);
        step();
        st_valid = 1'b0;
        check("mis_pulse", {31'd0, st_misalign}, 32'd1);
        check("mis_nowrite", {31'd0, dmem_write}, 32'd0);
        check("mis_empty", {31'd0, sb_empty}, 32'd1);
        step();
        check("mis_clear", {31'd0, st_misalign}, 32'd0);
        store(3'b001, 32'h0000_2001, 32'h0); step();
        store(3'b011, 32'h0000_2000, 32'h0); step();
        // legal sh upper half while resp held high in IDLE (ignored)
        dmem_resp = 1'b1;
        store(3'b001, 32'h0000_2002, 32'h0000_BEEF); step();
        st_valid = 1'b0; dmem_resp = 1'b0;
        check("sh_wmask", {28'd0, dmem_wmask}, 32'h0000_000C);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        dmem_resp = 1'b1; step(); dmem_resp = 1'b0; step();

        // forwarding: sw 0xDEADBEEF to 0x3000, head still in WRITE
        store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF); step();
        st_valid = 1'b0; ld_addr = 32'h0000_3000; #1;
`ifdef STORE_BUFFER_FWD_EN
        check("fwd_hit",  {31'd0, ld_fwd_hit}, 32'd1);
        check("fwd_data", ld_fwd_data, 32'hDEAD_BEEF);
        check("fwd_stall", {31'd0, ld_stall}, 32'd0);
`else
        check("nofwd_stall", {31'd0, ld_stall}, 32'd1);
        check("nofwd_hit", {31'd0, ld_fwd_hit}, 32'd0);
`endif
        step();
        // younger partial store to the same word: stall in both builds
        store(3'b000, 32'h0000_3001, 32'h0000_0055); step();
        st_valid = 1'b0;
        check("partial_stall", {31'd0, ld_stall}, 32'd1);
        check("partial_hit", {31'd0, ld_fwd_hit}, 32'd0);
        // push and pop on the same edge
        store(3'b010, 32'h0000_3008, 32'h0BAD_F00D); dmem_resp = 1'b1; step();
        st_valid = 1'b0; dmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); dmem_resp = 1'b1; step(); dmem_resp = 1'b0;
        end
        step();
        check("fwd_drained", {31'd0, sb_empty}, 32'd1);

        // fill: five sw with resp low, fifth held until a slot frees
        ld_addr = 32'h0000_4008;
        for (int i = 0; i < 4; i++) begin
            store(3'b010, 32'h0000_4000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
            step();
        end
        store(3'b010, 32'h0000_4010, 32'h5555_5555); step();
        check("full_ready", {31'd0, st_ready}, 32'd0);
        step();
        dmem_resp = 1'b1; step();
        dmem_resp = 1'b0;
        check("full_ready_after_pop", {31'd0, st_ready}, 32'd1);
        step();
        st_valid = 1'b0;
        check("order_second", dmem_address, 32'h0000_4004);
        for (int i = 0; i < 4; i++) begin
            dmem_resp = 1'b1; step(); dmem_resp = 1'b0; step();
        end
        check("fill_drained", {31'd0, sb_empty}, 32'd1);

        // reset during WRITE with three entries held
        for (int i = 0; i < 3; i++) begin
            store(3'b010, 32'h0000_5000 + 32'(4 * i), 32'h0000_0100 + 32'(i));
            step();
        end
        st_valid = 1'b0; ld_addr = 32'h0000_5004;
        check("pre_rst_write", {31'd0, dmem_write}, 32'd1);
        #1 rst = 1'b1;
        model_clear();
        #1;
        check("rst_drop_write", {31'd0, dmem_write}, 32'd0);
        check("rst_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_ready", {31'd0, st_ready}, 32'd1);
        check("rst_ld_stall", {31'd0, ld_stall}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dmem_resp = (i % 2) == 1; step();
        end
        dmem_resp = 1'b0;
        check("post_rst_nowrite", {31'd0, dmem_write}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
